// File: rtl/xmas_source_if.sv
// Initiator/target handshake channel: o_irdy/o_data from the initiator, i_trdy back from the target.
interface xmas_source_if #(
  parameter int DW = 32
) ();
  logic [DW-1:0] o_data;
  logic          o_irdy;
  logic          i_trdy;

  modport master (output o_data, output o_irdy, input i_trdy);
  modport slave  (input o_data, input o_irdy, output i_trdy);
endinterface

// File: rtl/xmas_source.sv
// Burst initiator: emits seed, seed+step, ... over the irdy/trdy channel,
// obeys target backpressure and reports transfer/stall counts and a stall timeout.
module xmas_source #(
  parameter int DW      = 32,
  parameter int LW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic [DW-1:0] seed,
  input  logic [DW-1:0] step,
  xmas_source_if.master bus,
  output logic          busy,
  output logic          done,
  output logic [LW-1:0] sent_cnt,
  output logic [LW-1:0] stall_cnt,
  output logic          err_timeout
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int RW = 32;
  localparam logic [RW-1:0] TIMEOUT_V = RW'(TIMEOUT);
  localparam logic [LW-1:0] CNT_MAX   = {LW{1'b1}};

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] data_q, data_d;
  logic [DW-1:0] step_q, step_d;
  logic [LW-1:0] remaining_q, remaining_d;
  logic [LW-1:0] sent_q, sent_d;
  logic [LW-1:0] stall_q, stall_d;
  logic [RW-1:0] run_q, run_d;
  logic          err_q, err_d;
  logic          irdy_q, irdy_d;
  logic          done_q, done_d;
  logic          transfer;

  assign transfer = irdy_q & bus.i_trdy;

  // Next-state logic: burst sequencing, counters and the sticky stall-timeout flag.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    step_d      = step_q;
    remaining_d = remaining_q;
    sent_d      = sent_q;
    stall_d     = stall_q;
    run_d       = run_q;
    err_d       = err_q;
    irdy_d      = irdy_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sent_d  = '0;
          stall_d = '0;
          run_d   = '0;
          err_d   = 1'b0;
          if (len != '0) begin
            state_d     = SEND;
            data_d      = seed;
            step_d      = step;
            remaining_d = len;
            irdy_d      = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (transfer) begin
          sent_d      = sent_q + LW'(1);
          remaining_d = remaining_q - LW'(1);
          run_d       = '0;
          if (remaining_q == LW'(1)) begin
            state_d = DONE;
            irdy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            data_d = data_q + step_q;
          end
        end else begin
          if (stall_q != CNT_MAX) begin
            stall_d = stall_q + LW'(1);
          end
          if (run_q != TIMEOUT_V) begin
            run_d = run_q + RW'(1);
          end
          if ((TIMEOUT != 0) && (run_q + RW'(1) == TIMEOUT_V)) begin
            err_d = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        irdy_d  = 1'b0;
      end
    endcase
  end

  // State register; reset aborts any burst and drops o_irdy at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      step_q      <= '0;
      remaining_q <= '0;
      sent_q      <= '0;
      stall_q     <= '0;
      run_q       <= '0;
      err_q       <= 1'b0;
      irdy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      step_q      <= step_d;
      remaining_q <= remaining_d;
      sent_q      <= sent_d;
      stall_q     <= stall_d;
      run_q       <= run_d;
      err_q       <= err_d;
      irdy_q      <= irdy_d;
      done_q      <= done_d;
    end
  end

  assign bus.o_data  = data_q;
  assign bus.o_irdy  = irdy_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign sent_cnt    = sent_q;
  assign stall_cnt   = stall_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_xmas_source.sv
// Testbench for xmas_source: scenario tasks drive bursts with random backpressure
// and compare every cycle against a word-index/stall-run reference model.
module tb_xmas_source;
  localparam int DW = 32;
  localparam int LW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic [DW-1:0] seed = '0;
  logic [DW-1:0] step = '0;
  logic          busy;
  logic          done;
  logic [LW-1:0] sent_cnt;
  logic [LW-1:0] stall_cnt;
  logic          err_timeout;

  int checks = 0;
  int errors = 0;

  xmas_source_if #(.DW(DW)) bus ();

  xmas_source #(.DW(DW), .LW(LW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .seed       (seed),
    .step       (step),
    .bus        (bus.master),
    .busy       (busy),
    .done       (done),
    .sent_cnt   (sent_cnt),
    .stall_cnt  (stall_cnt),
    .err_timeout(err_timeout)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // One burst: mode 0 = trdy always high, 1 = random trdy, 2 = hold trdy low stallLen cycles at word stallAt.
  task automatic runBurst(input logic [DW-1:0] s, input logic [DW-1:0] st, input logic [LW-1:0] n,
                          input int mode, input int stallAt, input int stallLen, input bit noise);
    logic [DW-1:0] expData;
    int  k = 0;
    int  stalls = 0;
    int  run = 0;
    int  stallDone = 0;
    int  cyc = 0;
    int  budget;
    bit  errM = 1'b0;
    bit  tr;
    budget = int'(n) * 20 + stallLen + 100;
    @(negedge clk);
    start = 1'b1; len = n; seed = s; step = st;
    bus.i_trdy = 1'($urandom_range(0, 1));
    @(negedge clk);
    start = 1'b0; len = LW'($urandom); seed = $urandom; step = $urandom;
    while (k < int'(n) && cyc < budget) begin
      expData = s + st * DW'(k);
      checks += 7;
      if (bus.o_irdy !== 1'b1) begin errors++; $display("[TB] FAIL irdy word %0d: got %b want 1", k, bus.o_irdy); end
      if (bus.o_data !== expData) begin errors++; $display("[TB] FAIL data word %0d: got %h want %h", k, bus.o_data, expData); end
      if (busy !== 1'b1) begin errors++; $display("[TB] FAIL busy word %0d: got %b want 1", k, busy); end
      if (done !== 1'b0) begin errors++; $display("[TB] FAIL done early word %0d: got %b want 0", k, done); end
      if (err_timeout !== errM) begin errors++; $display("[TB] FAIL err_timeout word %0d: got %b want %b", k, err_timeout, errM); end
      if (sent_cnt !== LW'(k)) begin errors++; $display("[TB] FAIL sent_cnt: got %0d want %0d", sent_cnt, k); end
      if (stall_cnt !== LW'(stalls)) begin errors++; $display("[TB] FAIL stall_cnt: got %0d want %0d", stall_cnt, stalls); end
      case (mode)
        0:       tr = 1'b1;
        1:       tr = ($urandom_range(0, 3) != 0);
        default: tr = !(k == stallAt && stallDone < stallLen);
      endcase
      bus.i_trdy = tr;
      if (noise) begin
        start = 1'($urandom_range(0, 1)); len = LW'($urandom); seed = $urandom; step = $urandom;
      end
      @(negedge clk);
      cyc++;
      if (tr) begin
        k++;
        run = 0;
      end else begin
        if (stalls < 65535) stalls++;
        run++;
        stallDone++;
        if (run == TO) errM = 1'b1;
      end
    end
    if (k < int'(n)) begin
      checks++; errors++;
      $display("[TB] FAIL burst timeout: sent %0d want %0d", k, n);
    end
    start = 1'b0;
    checks += 6;
    if (bus.o_irdy !== 1'b0) begin errors++; $display("[TB] FAIL irdy after last: got %b want 0", bus.o_irdy); end
    if (done !== 1'b1) begin errors++; $display("[TB] FAIL done pulse: got %b want 1", done); end
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL busy in done: got %b want 1", busy); end
    if (sent_cnt !== n) begin errors++; $display("[TB] FAIL final sent_cnt: got %0d want %0d", sent_cnt, n); end
    if (stall_cnt !== LW'(stalls)) begin errors++; $display("[TB] FAIL final stall_cnt: got %0d want %0d", stall_cnt, stalls); end
    if (err_timeout !== errM) begin errors++; $display("[TB] FAIL final err_timeout: got %b want %b", err_timeout, errM); end
    if (noise) begin
      start = 1'b1; len = LW'($urandom_range(1, 9)); seed = $urandom; step = $urandom;
    end
    bus.i_trdy = 1'($urandom_range(0, 1));
    @(negedge clk);
    start = 1'b0;
    bus.i_trdy = 1'b0;
    checks += 6;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL busy after done: got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL done width: got %b want 0", done); end
    if (bus.o_irdy !== 1'b0) begin errors++; $display("[TB] FAIL irdy in idle: got %b want 0", bus.o_irdy); end
    if (sent_cnt !== n) begin errors++; $display("[TB] FAIL sent_cnt hold: got %0d want %0d", sent_cnt, n); end
    if (stall_cnt !== LW'(stalls)) begin errors++; $display("[TB] FAIL stall_cnt hold: got %0d want %0d", stall_cnt, stalls); end
    if (err_timeout !== errM) begin errors++; $display("[TB] FAIL err hold: got %b want %b", err_timeout, errM); end
  endtask

  // Reset values while rst_n is held low.
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks += 7;
    if (bus.o_irdy !== 1'b0) begin errors++; $display("[TB] FAIL reset irdy: got %b want 0", bus.o_irdy); end
    if (bus.o_data !== '0) begin errors++; $display("[TB] FAIL reset data: got %h want 0", bus.o_data); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset busy: got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset done: got %b want 0", done); end
    if (sent_cnt !== '0) begin errors++; $display("[TB] FAIL reset sent_cnt: got %0d want 0", sent_cnt); end
    if (stall_cnt !== '0) begin errors++; $display("[TB] FAIL reset stall_cnt: got %0d want 0", stall_cnt); end
    if (err_timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset err: got %b want 0", err_timeout); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Simple 4-word incrementing burst with no backpressure.
  task automatic test_basic();
    runBurst(32'h10, 32'h1, 16'd4, 0, 0, 0, 1'b0);
  endtask

  // Five-cycle stall on the second word; word must stay offered.
  task automatic test_stall();
    runBurst($urandom, 32'h2, 16'd3, 2, 1, 5, 1'b0);
  endtask

  // Data increment wraps modulo 2^DW.
  task automatic test_wrap();
    runBurst(32'hFFFF_FFFF, 32'h1, 16'd2, 0, 0, 0, 1'b0);
  endtask

  // Stall run reaches TIMEOUT; flag is sticky through completion and idle.
  task automatic test_timeout();
    runBurst(32'hA000, 32'h3, 16'd4, 2, 2, TO, 1'b0);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (err_timeout !== 1'b1) begin errors++; $display("[TB] FAIL err sticky in idle: got %b want 1", err_timeout); end
    end
  endtask

  // Zero-length start: done next cycle, no irdy, counters and flag clear.
  task automatic test_len_zero();
    @(negedge clk);
    start = 1'b1; len = '0; seed = $urandom; step = $urandom;
    @(negedge clk);
    start = 1'b0;
    checks += 6;
    if (done !== 1'b1) begin errors++; $display("[TB] FAIL len0 done: got %b want 1", done); end
    if (bus.o_irdy !== 1'b0) begin errors++; $display("[TB] FAIL len0 irdy: got %b want 0", bus.o_irdy); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL len0 busy: got %b want 0", busy); end
    if (sent_cnt !== '0) begin errors++; $display("[TB] FAIL len0 sent_cnt: got %0d want 0", sent_cnt); end
    if (stall_cnt !== '0) begin errors++; $display("[TB] FAIL len0 stall_cnt: got %0d want 0", stall_cnt); end
    if (err_timeout !== 1'b0) begin errors++; $display("[TB] FAIL len0 err: got %b want 0", err_timeout); end
    @(negedge clk);
    checks += 2;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL len0 done width: got %b want 0", done); end
    if (bus.o_irdy !== 1'b0) begin errors++; $display("[TB] FAIL len0 irdy late: got %b want 0", bus.o_irdy); end
  endtask

  // Start pulses with junk parameters during SEND and DONE must be ignored.
  task automatic test_busy_start();
    runBurst($urandom, $urandom, 16'd7, 1, 0, 0, 1'b1);
    runBurst($urandom, $urandom, 16'd1, 0, 0, 0, 1'b1);
  endtask

  // Random bursts under random backpressure.
  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      runBurst($urandom, $urandom, LW'($urandom_range(1, 20)), 1, 0, 0, 1'($urandom_range(0, 1)));
    end
  endtask

  // Asynchronous reset in the middle of a 6-word burst, then a clean burst.
  task automatic test_reset_mid_burst();
    @(negedge clk);
    start = 1'b1; len = 16'd6; seed = $urandom; step = $urandom;
    bus.i_trdy = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (sent_cnt !== 16'd2) begin errors++; $display("[TB] FAIL pre-reset sent_cnt: got %0d want 2", sent_cnt); end
    #2 rst_n = 1'b0;
    #1;
    checks += 6;
    if (bus.o_irdy !== 1'b0) begin errors++; $display("[TB] FAIL async reset irdy: got %b want 0", bus.o_irdy); end
    if (bus.o_data !== '0) begin errors++; $display("[TB] FAIL async reset data: got %h want 0", bus.o_data); end
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL async reset busy: got %b want 0", busy); end
    if (sent_cnt !== '0) begin errors++; $display("[TB] FAIL async reset sent_cnt: got %0d want 0", sent_cnt); end
    if (stall_cnt !== '0) begin errors++; $display("[TB] FAIL async reset stall_cnt: got %0d want 0", stall_cnt); end
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL async reset done: got %b want 0", done); end
    bus.i_trdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL post-reset busy: got %b want 0", busy); end
    if (bus.o_irdy !== 1'b0) begin errors++; $display("[TB] FAIL post-reset irdy: got %b want 0", bus.o_irdy); end
    runBurst($urandom, $urandom, 16'd6, 1, 0, 0, 1'b0);
  endtask

  // Scenario sequence and summary.
  initial begin
    bus.i_trdy = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_timeout();
    test_len_zero();
    test_busy_start();
    test_random();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
